// File: rtl/grey_counter.sv
// grey_counter: registered Gray-code counter with up/down, clear and load.
// Optional `GREY_COUNTER_SYNC_EN adds a synchronised external grey pointer and fill level.
module grey_counter #(
    parameter int               WIDTH     = 4,
    parameter logic [WIDTH-1:0] RESET_BIN = '0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clear,
    input  logic             load,
    input  logic             load_is_grey,
    input  logic [WIDTH-1:0] load_val,
    input  logic             en,
    input  logic             up_dn,
`ifdef GREY_COUNTER_SYNC_EN
    input  logic [WIDTH-1:0] ext_grey,
    output logic [WIDTH-1:0] sync_bin,
    output logic [WIDTH-1:0] level,
`endif
    output logic [WIDTH-1:0] bin_out,
    output logic [WIDTH-1:0] grey_out,
    output logic             wrap
);

    localparam logic [WIDTH-1:0] RESET_GREY = RESET_BIN ^ (RESET_BIN >> 1);

    function automatic logic [WIDTH-1:0] g2b(input logic [WIDTH-1:0] g);
        logic [WIDTH-1:0] b;
        b[WIDTH-1] = g[WIDTH-1];
        for (int i = WIDTH - 2; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

    logic [WIDTH-1:0] r_bin;
    logic [WIDTH-1:0] r_grey;
    logic             r_wrap;
    logic [WIDTH-1:0] w_bin_next;
    logic [WIDTH-1:0] w_grey_next;
    logic             w_wrap_next;

    // next binary value and wrap flag, priority clear > load > en
    always_comb begin
        w_bin_next  = r_bin;
        w_wrap_next = 1'b0;
        if (clear) begin
            w_bin_next = RESET_BIN;
        end else if (load) begin
            w_bin_next = load_is_grey ? g2b(load_val) : load_val;
        end else if (en) begin
            if (up_dn) begin
                w_bin_next  = r_bin + WIDTH'(1);
                w_wrap_next = &r_bin;
            end else begin
                w_bin_next  = r_bin - WIDTH'(1);
                w_wrap_next = ~|r_bin;
            end
        end
        w_grey_next = w_bin_next ^ (w_bin_next >> 1);
    end

    // binary and grey registered on the same edge so grey_out never glitches
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_bin  <= RESET_BIN;
            r_grey <= RESET_GREY;
            r_wrap <= 1'b0;
        end else begin
            r_bin  <= w_bin_next;
            r_grey <= w_grey_next;
            r_wrap <= w_wrap_next;
        end
    end

    assign bin_out  = r_bin;
    assign grey_out = r_grey;
    assign wrap     = r_wrap;

`ifdef GREY_COUNTER_SYNC_EN
    logic [WIDTH-1:0] r_sync1;
    logic [WIDTH-1:0] r_sync2;
    logic [WIDTH-1:0] r_sync_bin;
    logic [WIDTH-1:0] r_level;

    // two-flop synchroniser, grey decode, then distance to local count
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_sync1    <= '0;
            r_sync2    <= '0;
            r_sync_bin <= '0;
            r_level    <= '0;
        end else begin
            r_sync1    <= ext_grey;
            r_sync2    <= r_sync1;
            r_sync_bin <= g2b(r_sync2);
            r_level    <= r_bin - r_sync_bin;
        end
    end

    assign sync_bin = r_sync_bin;
    assign level    = r_level;
`endif

endmodule

// File: tb/tb_grey_counter.sv
// tb_grey_counter: directed checks of grey_counter (WIDTH=4) plus a
// randomised single-bit-change run on a WIDTH=8 instance.
module tb_grey_counter;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       clear;
    logic       load;
    logic       load_is_grey;
    logic [3:0] load_val;
    logic       en;
    logic       up_dn;
    logic [3:0] bin_out;
    logic [3:0] grey_out;
    logic       wrap;

    logic       rst8_n;
    logic       en8;
    logic       up8;
    logic [7:0] bin8;
    logic [7:0] grey8;
    logic       wrap8;

`ifdef GREY_COUNTER_SYNC_EN
    logic [3:0] ext_grey;
    logic [3:0] sync_bin;
    logic [3:0] level;
    logic [7:0] sync8;
    logic [7:0] level8;
`endif

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    grey_counter #(.WIDTH(4), .RESET_BIN(4'd0)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .clear        (clear),
        .load         (load),
        .load_is_grey (load_is_grey),
        .load_val     (load_val),
        .en           (en),
        .up_dn        (up_dn),
`ifdef GREY_COUNTER_SYNC_EN
        .ext_grey     (ext_grey),
        .sync_bin     (sync_bin),
        .level        (level),
`endif
        .bin_out      (bin_out),
        .grey_out     (grey_out),
        .wrap         (wrap)
    );

    grey_counter #(.WIDTH(8), .RESET_BIN(8'hA5)) dut8 (
        .clk          (clk),
        .rst_n        (rst8_n),
        .clear        (1'b0),
        .load         (1'b0),
        .load_is_grey (1'b0),
        .load_val     (8'h00),
        .en           (en8),
        .up_dn        (up8),
`ifdef GREY_COUNTER_SYNC_EN
        .ext_grey     (8'h00),
        .sync_bin     (sync8),
        .level        (level8),
`endif
        .bin_out      (bin8),
        .grey_out     (grey8),
        .wrap         (wrap8)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    logic [3:0] gtab [16];
    logic [7:0] m8;
    logic [7:0] pg8;
    logic       mw8;
    logic [3:0] e4;

    initial begin
        gtab = '{4'h0, 4'h1, 4'h3, 4'h2, 4'h6, 4'h7, 4'h5, 4'h4,
                 4'hC, 4'hD, 4'hF, 4'hE, 4'hA, 4'hB, 4'h9, 4'h8};
        rst_n = 1'b0; clear = 1'b0; load = 1'b0; load_is_grey = 1'b0;
        load_val = 4'h0; en = 1'b0; up_dn = 1'b1;
        rst8_n = 1'b0; en8 = 1'b0; up8 = 1'b1;
`ifdef GREY_COUNTER_SYNC_EN
        ext_grey = 4'h0;
`endif
        step();
        step();
        chk("rst_bin", 32'(bin_out), 32'h0);
        chk("rst_grey", 32'(grey_out), 32'h0);
        chk("rst_wrap", 32'(wrap), 32'h0);
        chk("rst8_bin", 32'(bin8), 32'hA5);
        chk("rst8_grey", 32'(grey8), 32'hF7);

        rst_n = 1'b1; en = 1'b1; up_dn = 1'b1;
        for (int i = 1; i <= 16; i++) begin
            step();
            e4 = 4'(i);
            chk("up_bin", 32'(bin_out), 32'(e4));
            chk("up_grey", 32'(grey_out), 32'(gtab[e4]));
            chk("up_wrap", 32'(wrap), (i == 16) ? 32'h1 : 32'h0);
        end

        step();
        chk("pre_dn_bin", 32'(bin_out), 32'h1);
        up_dn = 1'b0;
        step();
        chk("dn0_bin", 32'(bin_out), 32'h0);
        chk("dn0_grey", 32'(grey_out), 32'h0);
        chk("dn0_wrap", 32'(wrap), 32'h0);
        step();
        chk("dn1_bin", 32'(bin_out), 32'hF);
        chk("dn1_grey", 32'(grey_out), 32'h8);
        chk("dn1_wrap", 32'(wrap), 32'h1);
        step();
        chk("dn2_bin", 32'(bin_out), 32'hE);
        chk("dn2_grey", 32'(grey_out), 32'h9);
        chk("dn2_wrap", 32'(wrap), 32'h0);

        en = 1'b0; load_is_grey = 1'b1; load_val = 4'hF;
        step();
        chk("idle_bin", 32'(bin_out), 32'hE);
        chk("idle_grey", 32'(grey_out), 32'h9);

        load = 1'b1; load_is_grey = 1'b1; load_val = 4'b1101;
        step();
        chk("gload_bin", 32'(bin_out), 32'h9);
        chk("gload_grey", 32'(grey_out), 32'hD);
        load_is_grey = 1'b0; load_val = 4'b0110;
        step();
        chk("bload_bin", 32'(bin_out), 32'h6);
        chk("bload_grey", 32'(grey_out), 32'h5);

        clear = 1'b1; en = 1'b1; up_dn = 1'b1; load_val = 4'hB;
        step();
        chk("clr_pri_bin", 32'(bin_out), 32'h0);
        chk("clr_pri_grey", 32'(grey_out), 32'h0);
        clear = 1'b0; load_val = 4'h7;
        step();
        chk("ld_pri_bin", 32'(bin_out), 32'h7);
        chk("ld_pri_grey", 32'(grey_out), 32'h4);
        rst_n = 1'b0; load_val = 4'h3;
        step();
        chk("rst_pri_bin", 32'(bin_out), 32'h0);
        chk("rst_pri_wrap", 32'(wrap), 32'h0);
        rst_n = 1'b1; load_val = 4'hF;
        step();
        load = 1'b0;
        step();
        chk("ldwrap_bin", 32'(bin_out), 32'h0);
        chk("ldwrap_wrap", 32'(wrap), 32'h1);
        clear = 1'b1;
        step();
        chk("clr_wrap", 32'(wrap), 32'h0);
        clear = 1'b0; en = 1'b0;

`ifdef GREY_COUNTER_SYNC_EN
        load = 1'b1; load_val = 4'd9;
        ext_grey = 4'b0111;
        step();
        load = 1'b0;
        step();
        step();
        chk("sync5", 32'(sync_bin), 32'd5);
        step();
        chk("level4", 32'(level), 32'd4);
        load = 1'b1; load_val = 4'd3;
        ext_grey = 4'b1010;
        step();
        load = 1'b0;
        step();
        step();
        chk("sync12", 32'(sync_bin), 32'd12);
        step();
        chk("level7", 32'(level), 32'd7);
`endif

        rst8_n = 1'b1;
        m8 = 8'hA5;
        for (int i = 0; i < 3000; i++) begin
            en8 = 1'($urandom_range(0, 1));
            up8 = 1'($urandom_range(0, 1));
            pg8 = grey8;
            mw8 = en8 && ((up8 && m8 == 8'hFF) || (!up8 && m8 == 8'h00));
            if (en8) m8 = up8 ? m8 + 8'd1 : m8 - 8'd1;
            step();
            chk("r8_bin", 32'(bin8), 32'(m8));
            chk("r8_grey", 32'(grey8), 32'(m8 ^ (m8 >> 1)));
            chk("r8_1bit", 32'($countones(grey8 ^ pg8)), en8 ? 32'd1 : 32'd0);
            chk("r8_wrap", 32'(wrap8), 32'(mw8));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
